// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and decode record for the ALU issue controller.
// Optional build macro: ALU_SHAMT_MASK_EN (consumed by alu_op_decode).
package alu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLL = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SRL = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] ALU_XOR = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SRA = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BEQ = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BNE = 4'b1001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BLT = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BGE = 4'b1011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLT = 4'b1100;
    localparam logic [OPCODE_LENGTH-1:0] ALU_LUI = 4'b1111;

    typedef enum logic [1:0] {
        SRCB_RS2       = 2'd0,
        SRCB_IMM       = 2'd1,
        SRCB_RS2_SHAMT = 2'd2,
        SRCB_IMM_SHAMT = 2'd3
    } src_b_sel_e;

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        src_b_sel_e               src_b_sel;
        logic                     wb_en;
        logic                     is_branch;
        logic                     illegal;
    } decoded_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Upstream, ALU and downstream signals of the issue controller.
// master = surrounding pipeline and ALU, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               in_opcode;
    logic [2:0]               in_funct3;
    logic [6:0]               in_funct7;
    logic [DATA_WIDTH-1:0]    in_rs1;
    logic [DATA_WIDTH-1:0]    in_rs2;
    logic [DATA_WIDTH-1:0]    in_imm;
    logic [4:0]               in_rd;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_result;
    logic [4:0]               out_rd;
    logic                     out_wb_en;
    logic                     out_branch_taken;
    logic                     out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_rd,
        output ALUResult, out_ready,
        input  in_ready, SrcA, SrcB, Operation,
        input  out_valid, out_result, out_rd, out_wb_en, out_branch_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_rd,
        input  ALUResult, out_ready,
        output in_ready, SrcA, SrcB, Operation,
        output out_valid, out_result, out_rd, out_wb_en, out_branch_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode/funct3/funct7 decode into the ALU operation and operand-B source.
// ALU_SHAMT_MASK_EN: R-type shifts take only rs2[4:0] on SrcB instead of the full rs2.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       imm_b10,
    output decoded_t   dec
);

`ifdef ALU_SHAMT_MASK_EN
    localparam src_b_sel_e R_SHIFT_SEL = SRCB_RS2_SHAMT;
`else
    localparam src_b_sel_e R_SHIFT_SEL = SRCB_RS2;
`endif

    logic is_i;
    logic alt;

    assign is_i = (opcode == OP_I);
    // SUB/SRA selector: funct7[5] for register forms, imm[10] for immediate forms
    assign alt  = is_i ? imm_b10 : funct7_b5;

    always_comb begin
        dec = '{op: ALU_AND, src_b_sel: SRCB_RS2, wb_en: 1'b0, is_branch: 1'b0, illegal: 1'b1};
        case (opcode)
            OP_R, OP_I: begin
                dec.illegal   = 1'b0;
                dec.wb_en     = 1'b1;
                dec.src_b_sel = is_i ? SRCB_IMM : SRCB_RS2;
                case (funct3)
                    3'b000: dec.op = (!is_i && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b111: dec.op = ALU_AND;
                    3'b110: dec.op = ALU_OR;
                    3'b100: dec.op = ALU_XOR;
                    3'b010: dec.op = ALU_SLT;
                    3'b001: begin
                        dec.op        = ALU_SLL;
                        dec.src_b_sel = is_i ? SRCB_IMM_SHAMT : R_SHIFT_SEL;
                    end
                    3'b101: begin
                        dec.op        = alt ? ALU_SRA : ALU_SRL;
                        dec.src_b_sel = is_i ? SRCB_IMM_SHAMT : R_SHIFT_SEL;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                        dec.wb_en   = 1'b0;
                    end
                endcase
            end
            OP_LUI: begin
                dec.op        = ALU_LUI;
                dec.src_b_sel = SRCB_IMM;
                dec.wb_en     = 1'b1;
                dec.illegal   = 1'b0;
            end
            OP_BR: begin
                dec.is_branch = 1'b1;
                dec.illegal   = 1'b0;
                case (funct3)
                    3'b000:  dec.op = ALU_BEQ;
                    3'b001:  dec.op = ALU_BNE;
                    3'b100:  dec.op = ALU_BLT;
                    3'b101:  dec.op = ALU_BGE;
                    default: begin
                        dec.is_branch = 1'b0;
                        dec.illegal   = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue controller: S1 registers ALU operands/operation, S2 captures ALUResult.
// Build option ALU_SHAMT_MASK_EN is handled inside alu_op_decode.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);

    decoded_t dec;

    alu_op_decode u_decode (
        .opcode    (bus.in_opcode),
        .funct3    (bus.in_funct3),
        .funct7_b5 (bus.in_funct7[5]),
        .imm_b10   (bus.in_imm[10]),
        .dec       (dec)
    );

    logic                  accept;
    logic                  advance2;
    logic [DATA_WIDTH-1:0] src_a_d;
    logic [DATA_WIDTH-1:0] src_b_d;

    always_comb begin
        src_a_d = (dec.op == ALU_LUI) ? '0 : bus.in_rs1;
        case (dec.src_b_sel)
            SRCB_IMM:       src_b_d = bus.in_imm;
            SRCB_RS2_SHAMT: src_b_d = {{(DATA_WIDTH-5){1'b0}}, bus.in_rs2[4:0]};
            SRCB_IMM_SHAMT: src_b_d = {{(DATA_WIDTH-5){1'b0}}, bus.in_imm[4:0]};
            default:        src_b_d = bus.in_rs2;
        endcase
    end

    // ---- S1: issue registers driving the ALU ----
    logic                     vld_p1;
    logic [DATA_WIDTH-1:0]    src_a_p1;
    logic [DATA_WIDTH-1:0]    src_b_p1;
    logic [OPCODE_LENGTH-1:0] op_p1;
    logic [4:0]               rd_p1;
    logic                     wb_en_p1;
    logic                     is_branch_p1;
    logic                     illegal_p1;

    // ---- S2: result registers ----
    logic                     vld_p2;
    logic [DATA_WIDTH-1:0]    result_p2;
    logic [4:0]               rd_p2;
    logic                     wb_en_p2;
    logic                     taken_p2;
    logic                     illegal_p2;

    assign advance2     = vld_p1 & (~vld_p2 | bus.out_ready);
    assign bus.in_ready = ~vld_p1 | advance2;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            src_a_p1     <= '0;
            src_b_p1     <= '0;
            op_p1        <= '0;
            rd_p1        <= '0;
            wb_en_p1     <= 1'b0;
            is_branch_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
        end else if (accept) begin
            vld_p1       <= 1'b1;
            src_a_p1     <= src_a_d;
            src_b_p1     <= src_b_d;
            op_p1        <= dec.op;
            rd_p1        <= bus.in_rd;
            // x0 is never written
            wb_en_p1     <= dec.wb_en & (bus.in_rd != 5'd0);
            is_branch_p1 <= dec.is_branch;
            illegal_p1   <= dec.illegal;
        end else if (advance2) begin
            vld_p1       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            result_p2  <= '0;
            rd_p2      <= '0;
            wb_en_p2   <= 1'b0;
            taken_p2   <= 1'b0;
            illegal_p2 <= 1'b0;
        end else if (advance2) begin
            vld_p2     <= 1'b1;
            result_p2  <= bus.ALUResult;
            rd_p2      <= rd_p1;
            wb_en_p2   <= wb_en_p1;
            taken_p2   <= is_branch_p1 & bus.ALUResult[0];
            illegal_p2 <= illegal_p1;
        end else if (bus.out_ready) begin
            vld_p2     <= 1'b0;
        end
    end

    assign bus.SrcA             = src_a_p1;
    assign bus.SrcB             = src_b_p1;
    assign bus.Operation        = op_p1;
    assign bus.out_valid        = vld_p2;
    assign bus.out_result       = result_p2;
    assign bus.out_rd           = rd_p2;
    assign bus.out_wb_en        = wb_en_p2;
    assign bus.out_branch_taken = taken_p2;
    assign bus.out_illegal      = illegal_p2;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Pipelined issue controller that drives the 32-bit datapath ALU. Accepts decoded instruction fields and register operands over a valid/ready handshake, selects SrcA/SrcB and the 4-bit Operation code, registers them toward the ALU, then captures ALUResult into an output stage with writeback and branch-taken qualifiers. Sits between register-read and writeback in the core pipeline; it is the initiator side of the ALU's SrcA/SrcB/Operation/ALUResult interface.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU Operation width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept this cycle
- in_opcode  input  7  RISC-V opcode field
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field
- in_rs1  input  DATA_WIDTH  rs1 value
- in_rs2  input  DATA_WIDTH  rs2 value
- in_imm  input  DATA_WIDTH  sign-extended immediate (upper-aligned for LUI)
- in_rd  input  5  destination register
- SrcA  output  DATA_WIDTH  ALU operand A, registered
- SrcB  output  DATA_WIDTH  ALU operand B, registered
- Operation  output  OPCODE_LENGTH  ALU operation, registered
- ALUResult  input  DATA_WIDTH  combinational ALU result for current SrcA/SrcB/Operation
- out_valid  output  1  result stage valid
- out_ready  input  1  downstream accepts
- out_result  output  DATA_WIDTH  captured ALUResult
- out_rd  output  5  destination register
- out_wb_en  output  1  result to be written to out_rd
- out_branch_taken  output  1  branch condition true
- out_illegal  output  1  instruction not decodable

## Operation
- Two stages: S1 (issue regs: SrcA, SrcB, Operation, rd, class flags, s1_valid), S2 (result regs, out_valid).
- Decode, R-type 0110011: funct3 000 → ADD 0010 (funct7[5]=0) / SUB 0011 (funct7[5]=1); 111 AND 0000; 110 OR 0001; 100 XOR 0110; 001 SLL 0100; 101 SRL 0101 / SRA 0111 by funct7[5]; 010 SLT 1100. SrcB = rs2.
- I-type 0010011: same mapping, SrcB = imm; 000 always ADD; 101 SRA when imm[10]=1; shifts use SrcB = zero-extended imm[4:0].
- LUI 0110111: Operation 1111, SrcB = imm, SrcA = 0.
- Branch 1100011: 000 BEQ 1000; 001 BNE 1001; 100 BLT 1010; 101 BGE 1011. wb_en = 0; branch_taken = ALUResult[0].
- All others: illegal = 1, Operation 0000, wb_en = 0, branch_taken = 0; still flows through pipeline.
- out_rd = 0 forces out_wb_en = 0.
- S2 captures ALUResult while S1 valid and S2 free or draining.

## Timing
- Latency: in_valid&in_ready at edge N → S1 valid after N; out_valid after N+1.
- Throughput one per cycle when out_ready held high.
- advance2 = s1_valid & (!out_valid | out_ready); in_ready = !s1_valid | advance2 (combinational, no skid).
- out_valid holds with all out_* stable until out_ready; S1 outputs (SrcA/SrcB/Operation) stable while stalled.
- Simultaneous accept and drain in same cycle: both occur, no bubble.
- Reset (any time, including mid-stall): s1_valid = 0, out_valid = 0, SrcA = SrcB = 0, Operation = 0000, out_result = 0, out_rd = 0, out_wb_en = out_branch_taken = out_illegal = 0; in-flight instructions discarded; in_ready = 1 after reset release.

## Configuration
- ALU_SHAMT_MASK_EN defined: R-type shifts drive SrcB = zero-extended rs2[4:0].
- Undefined: R-type shifts drive full rs2 on SrcB. I-type shifts always masked.

## Structure
- Package alu_pkg: opcode constants (OP_R, OP_I, OP_LUI, OP_BR), 4-bit ALU op localparams (ALU_AND … ALU_LUI), typedef struct decoded_t {op, src_b_sel, wb_en, is_branch, illegal}.
- One sub-module: alu_op_decode (combinational opcode/funct → decoded_t); alu_issue_ctrl holds pipeline regs and handshake.

## Test plan
- Reset mid-stall with out_valid=1, out_ready=0 → all outputs zero, in_ready=1 next cycle.
- ADD rs1=5 rs2=7, then SUB funct7=0100000 rs1=5 rs2=7 back-to-back, out_ready=1 → Operation 0010 then 0011; out_result 12 then 0xFFFFFFFE on consecutive cycles, wb_en=1.
- BEQ rs1=rs2=0x10 → Operation 1000, out_branch_taken=1, out_wb_en=0; BNE same operands → taken=0.
- SLL rs2=0x21, rs1=1: with ALU_SHAMT_MASK_EN SrcB=1, out_result=2; without, SrcB=0x21.
- out_ready=0 for 3 cycles with 3 instructions offered → exactly 2 held (S1,S2), in_ready=0, outputs stable; release → in-order drain, no loss/duplication.
- opcode 0000000 → out_illegal=1, wb_en=0; LUI imm=0xABCDE000 rd=0 → out_result=0xABCDE000, out_wb_en=0.
